mac_tx_framer: RTL and testbench



---
 rtl/mac_tx_framer.sv | 254 +++++++++++++++++++++++++
 tb/tb_mac_tx_framer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : mac_tx_framer
// Description : Byte-wide Ethernet transmit framer. Accepts a frame as a
//               valid/ready byte stream and drives the MII converter's
//               byte-side inputs. Adds preamble and SFD, optionally pads
//               short frames, appends the CRC-32 FCS and enforces the
//               inter-frame gap. One byte per clock.
//
// Ports       : clock        MAC transmit clock
//               reset        synchronous, active-high
//               data_in      frame byte, DA first
//               data_valid   data_in valid
//               data_last    final frame byte (qualified by data_valid)
//               data_ready   byte accepted on data_valid & data_ready
//                            (combinational state decode)
//               mac_txd      registered byte to the MII converter
//               mac_tx_en    registered transmit enable
//               mac_tx_er    registered transmit error
//               tx_busy      registered, high whenever state is not IDLE
//               tx_underrun  registered one-cycle pulse on frame abort
//
// Config      : MAC_TX_PAD_EN - when defined, frames shorter than MIN_FRAME
//               are zero-padded (pad included in the CRC). When undefined,
//               frames are sent as supplied and MIN_FRAME only feeds an
//               elaboration range check.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic [7:0] mac_txd,
    output logic       mac_tx_en,
    output logic       mac_tx_er,
    output logic       tx_busy,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        DATA     = 3'd3,
        PAD      = 3'd4,
        FCS      = 3'd5,
        IFG      = 3'd6
    } state_t;

    // One phase counter serves the preamble (7), FCS (4) and IFG counts.
    localparam int                   c_phase_w   = (IFG_BYTES > 8) ? $clog2(IFG_BYTES) : 3;
    localparam logic [c_phase_w-1:0] c_pre_last  = c_phase_w'(6);
    localparam logic [c_phase_w-1:0] c_ifg_last  = c_phase_w'(IFG_BYTES - 1);
    localparam logic [31:0]          c_crc_poly  = 32'hEDB88320;
    localparam logic [31:0]          c_crc_init  = 32'hFFFFFFFF;
    localparam logic [10:0]          c_cnt_max   = 11'h7FF;
    localparam logic [7:0]           c_pre_byte  = 8'h55;
    localparam logic [7:0]           c_sfd_byte  = 8'hD5;
`ifdef MAC_TX_PAD_EN
    localparam logic [10:0]          c_min_frame = 11'(MIN_FRAME);
`endif

    // A minimum length the 11-bit byte counter can never reach is a
    // configuration error.
    generate
        if (MIN_FRAME < 1 || MIN_FRAME > 2047) begin : g_min_frame_range
            $error("mac_tx_framer: MIN_FRAME out of range 1..2047");
        end
    endgenerate

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
        end
        return c;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_phase_w-1:0] r_phase;
    logic [c_phase_w-1:0] w_phase_nxt;
    logic [10:0]          r_byte_cnt;
    logic [10:0]          w_byte_cnt_nxt;
    logic [10:0]          w_cnt_inc;
    logic [31:0]          r_crc;
    logic [31:0]          w_crc_nxt;
    logic [31:0]          w_fcs_word;
    logic [7:0]           w_fcs_byte;
    logic [7:0]           r_txd;
    logic [7:0]           w_txd_nxt;
    logic                 r_tx_en;
    logic                 w_tx_en_nxt;
    logic                 r_tx_er;
    logic                 w_tx_er_nxt;
    logic                 r_underrun;
    logic                 w_underrun_nxt;
    logic                 r_busy;
    logic                 w_ready;

    assign w_ready    = (r_state == SFD) || (r_state == DATA);
    assign w_cnt_inc  = (r_byte_cnt == c_cnt_max) ? r_byte_cnt : r_byte_cnt + 11'd1;
    assign w_fcs_word = ~r_crc;

    always_comb begin
        w_fcs_byte = w_fcs_word[7:0];
        case (r_phase[1:0])
            2'd0:    w_fcs_byte = w_fcs_word[7:0];
            2'd1:    w_fcs_byte = w_fcs_word[15:8];
            2'd2:    w_fcs_byte = w_fcs_word[23:16];
            default: w_fcs_byte = w_fcs_word[31:24];
        endcase
    end

    // The output registers are loaded with the byte belonging to the state
    // being entered, so mac_txd trails the state by exactly one cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_byte_cnt_nxt = r_byte_cnt;
        w_crc_nxt      = r_crc;
        w_txd_nxt      = 8'h00;
        w_tx_en_nxt    = 1'b0;
        w_tx_er_nxt    = 1'b0;
        w_underrun_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_byte_cnt_nxt = 11'd0;
                w_crc_nxt      = c_crc_init;
                w_phase_nxt    = '0;
                if (data_valid) begin
                    w_state_nxt = PREAMBLE;
                    w_txd_nxt   = c_pre_byte;
                    w_tx_en_nxt = 1'b1;
                end
            end

            PREAMBLE: begin
                w_tx_en_nxt = 1'b1;
                if (r_phase == c_pre_last) begin
                    w_txd_nxt   = c_sfd_byte;
                    w_phase_nxt = '0;
                    w_state_nxt = SFD;
                end else begin
                    w_txd_nxt   = c_pre_byte;
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            SFD, DATA: begin
                w_tx_en_nxt = 1'b1;
                if (data_valid) begin
                    w_txd_nxt      = data_in;
                    w_byte_cnt_nxt = w_cnt_inc;
                    w_crc_nxt      = crc32_byte(r_crc, data_in);
                    w_state_nxt    = DATA;
                    if (data_last) begin
                        w_phase_nxt = '0;
`ifdef MAC_TX_PAD_EN
                        w_state_nxt = (w_cnt_inc < c_min_frame) ? PAD : FCS;
`else
                        w_state_nxt = FCS;
`endif
                    end
                end else begin
                    // Source ran dry mid-frame: poison the frame and skip FCS.
                    w_tx_er_nxt    = 1'b1;
                    w_underrun_nxt = 1'b1;
                    w_phase_nxt    = '0;
                    w_state_nxt    = IFG;
                end
            end

`ifdef MAC_TX_PAD_EN
            PAD: begin
                w_tx_en_nxt    = 1'b1;
                w_byte_cnt_nxt = w_cnt_inc;
                w_crc_nxt      = crc32_byte(r_crc, 8'h00);
                if (w_cnt_inc >= c_min_frame) begin
                    w_phase_nxt = '0;
                    w_state_nxt = FCS;
                end
            end
`endif

            FCS: begin
                w_tx_en_nxt = 1'b1;
                w_txd_nxt   = w_fcs_byte;
                if (r_phase[1:0] == 2'd3) begin
                    w_phase_nxt = '0;
                    w_state_nxt = IFG;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            IFG: begin
                if (r_phase == c_ifg_last) begin
                    w_phase_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_byte_cnt <= 11'd0;
            r_crc      <= c_crc_init;
            r_txd      <= 8'h00;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_underrun <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_crc      <= w_crc_nxt;
            r_txd      <= w_txd_nxt;
            r_tx_en    <= w_tx_en_nxt;
            r_tx_er    <= w_tx_er_nxt;
            r_underrun <= w_underrun_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign data_ready  = w_ready;
    assign mac_txd     = r_txd;
    assign mac_tx_en   = r_tx_en;
    assign mac_tx_er   = r_tx_er;
    assign tx_busy     = r_busy;
    assign tx_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_tx_framer
// Description : Self-checking bench for mac_tx_framer. Expected transmit
//               bytes and frame lengths are queued when a frame is offered
//               and compared as the DUT transmits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tx_framer;

    localparam int MIN_FRAME = 60;
    localparam int IFG_BYTES = 12;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;
    logic [7:0] mac_txd;
    logic       mac_tx_en;
    logic       mac_tx_er;
    logic       tx_busy;
    logic       tx_underrun;

    mac_tx_framer #(
        .MIN_FRAME (MIN_FRAME),
        .IFG_BYTES (IFG_BYTES)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_last   (data_last),
        .data_ready  (data_ready),
        .mac_txd     (mac_txd),
        .mac_tx_en   (mac_tx_en),
        .mac_tx_er   (mac_tx_er),
        .tx_busy     (tx_busy),
        .tx_underrun (tx_underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: each entry is {underrun, tx_er, txd}.
    logic [9:0]  exp_q[$];
    int          len_q[$];
    logic [7:0]  fbuf[0:2047];

    int  expect_gap    = -1;
    int  expect_rise   = -1;
    bit  ignore_run    = 1'b0;
    bit  prev_en       = 1'b0;
    int  run_len       = 0;
    int  last_high_cyc = 0;

    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ fbuf[i][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    task automatic push_frame(input int len, input bit lit_fcs, input logic [31:0] lit);
        int          total;
        logic [31:0] fcs;
        total = len;
`ifdef MAC_TX_PAD_EN
        if (total < MIN_FRAME) begin
            for (int i = len; i < MIN_FRAME; i++) fbuf[i] = 8'h00;
            total = MIN_FRAME;
        end
`endif
        repeat (7) exp_q.push_back({2'b00, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
        for (int i = 0; i < total; i++) exp_q.push_back({2'b00, fbuf[i]});
        fcs = lit_fcs ? lit : ~crc_ref(total);
        for (int k = 0; k < 4; k++) exp_q.push_back({2'b00, fcs[8*k +: 8]});
        len_q.push_back(8 + total + 4);
    endtask

    task automatic push_abort(input int nbytes);
        repeat (7) exp_q.push_back({2'b00, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
        for (int i = 0; i < nbytes; i++) exp_q.push_back({2'b00, fbuf[i]});
        exp_q.push_back({2'b11, 8'h00});
        len_q.push_back(8 + nbytes + 1);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
    endtask

    // Offers fbuf[0..len-1]. abort_after >= 0 drops data_valid after that
    // many accepted bytes. keep_valid leaves data_valid high on return.
    task automatic send_frame(input int len, input int abort_after, input bit keep_valid);
        int i;
        int guard;
        bit acc;
        i     = 0;
        guard = 0;
        while (i < len && guard < 4000) begin
            data_valid = 1'b1;
            data_in    = fbuf[i];
            data_last  = (i == len - 1);
            @(negedge clock);
            acc = data_ready;
            @(posedge clock);
            #1;
            guard++;
            if (acc) begin
                i++;
                if (abort_after >= 0 && i == abort_after) break;
            end
        end
        if (guard >= 4000) check_eq("drv_timeout", 32'(i), 32'(len));
        data_last = 1'b0;
        if (abort_after >= 0) begin
            data_valid = 1'b0;
            @(posedge clock);
            #1;
        end else if (!keep_valid) begin
            data_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (tx_busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) check_eq("idle_timeout", 32'(tx_busy), 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clock) begin
        logic [9:0] e;
        if (mac_tx_en === 1'b1) begin
            if (!prev_en) begin
                if (expect_gap >= 0) begin
                    check_eq("ifg_gap", 32'(cyc - last_high_cyc - 1), 32'(expect_gap));
                    expect_gap = -1;
                end
                if (expect_rise >= 0) begin
                    check_eq("rise_after_reset", 32'(cyc), 32'(expect_rise));
                    expect_rise = -1;
                end
                run_len = 0;
            end
            run_len++;
            last_high_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("tx_en_unexpected", 32'(mac_tx_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("txd", 32'(mac_txd), 32'(e[7:0]));
                check_eq("tx_er", 32'(mac_tx_er), 32'(e[8]));
                check_eq("tx_underrun", 32'(tx_underrun), 32'(e[9]));
                check_eq("busy_in_frame", 32'(tx_busy), 32'd1);
            end
        end else begin
            if (prev_en) begin
                if (ignore_run) ignore_run = 1'b0;
                else if (len_q.size() > 0) check_eq("frame_len", 32'(run_len), 32'(len_q.pop_front()));
                else check_eq("frame_len_unexpected", 32'(run_len), 32'd0);
            end
            if (reset === 1'b0) check_eq("underrun_idle", 32'(tx_underrun), 32'd0);
        end
        prev_en = (mac_tx_en === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;
        data_last  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check_eq("idle_tx_en", 32'(mac_tx_en), 32'd0);
            check_eq("idle_txd", 32'(mac_txd), 32'd0);
            check_eq("idle_ready", 32'(data_ready), 32'd0);
            check_eq("idle_busy", 32'(tx_busy), 32'd0);
        end
        @(posedge clock);
        #1;

        // "123456789" with known check value.
        for (int i = 0; i < 9; i++) fbuf[i] = 8'(8'h31 + i);
`ifdef MAC_TX_PAD_EN
        push_frame(9, 1'b0, 32'h0);
`else
        push_frame(9, 1'b1, 32'hCBF43926);
`endif
        send_frame(9, -1, 1'b0);
        wait_idle();

        // 14-byte frame (padded to 60 when padding is built in).
        fill_random(14);
        push_frame(14, 1'b0, 32'h0);
        send_frame(14, -1, 1'b0);
        wait_idle();

        // Two back-to-back 64-byte frames, data_valid held high.
        fill_random(64);
        push_frame(64, 1'b0, 32'h0);
        send_frame(64, -1, 1'b1);
        fill_random(64);
        push_frame(64, 1'b0, 32'h0);
        expect_gap = IFG_BYTES;
        send_frame(64, -1, 1'b0);
        wait_idle();

        // Underrun after 5 bytes, then a normal frame.
        fill_random(20);
        push_abort(5);
        send_frame(20, 5, 1'b0);
        fill_random(20);
        push_frame(20, 1'b0, 32'h0);
        expect_gap = IFG_BYTES;
        send_frame(20, -1, 1'b0);
        wait_idle();

        // Reset while FCS byte 2 is on the wire.
        fill_random(64);
        push_frame(64, 1'b0, 32'h0);
        send_frame(64, -1, 1'b0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rst_txd", 32'(mac_txd), 32'd0);
        check_eq("rst_tx_en", 32'(mac_tx_en), 32'd0);
        check_eq("rst_tx_er", 32'(mac_tx_er), 32'd0);
        check_eq("rst_ready", 32'(data_ready), 32'd0);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_underrun", 32'(tx_underrun), 32'd0);
        exp_q.delete();
        len_q.delete();
        ignore_run = 1'b1;
        reset      = 1'b0;
        fill_random(20);
        push_frame(20, 1'b0, 32'h0);
        expect_rise = cyc + 1;
        send_frame(20, -1, 1'b0);
        wait_idle();

        repeat (5) @(negedge clock);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check_eq("len_q_drained", 32'(len_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
